// File: rtl/ps2_key_event_decoder.sv
// PS/2 set-2 byte stream to key make/break events, queued in a FWFT FIFO.
// Optional build macro: REPEAT_FILTER_EN suppresses typematic repeats and
// breaks of keys that are not held, using the held-key bitmap.
module ps2_key_event_decoder #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [7:0]                  rx_data,
  input  logic                        read_data,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [7:0]                  evt_code,
  output logic                        evt_ext,
  output logic                        evt_release,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StPause} state_e;

  state_e         state_q, state_d;
  logic [2:0]     skip_q, skip_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [511:0]   held_q, held_d;
  logic [9:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  rptr_q, wptr_q;
  logic [AW:0]    count_q, count_d;
  logic           ovf_q;
  logic [9:0]     last_q;

  logic           is_ctrl;
  logic           ev_valid, ev_ext, ev_rel, ev_keep;
  logic [7:0]     ev_code;
  logic           pop, full, push, drop;

  // Link-control bytes that never belong to a key sequence
  always_comb begin
    is_ctrl = 1'b0;
    case (rx_data)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_ctrl = 1'b1;
      default: is_ctrl = 1'b0;
    endcase
  end

  // Prefix decoder, pause skipper and sequence timeout
  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    tmo_d    = '0;
    ev_valid = 1'b0;
    ev_code  = rx_data;
    ev_ext   = 1'b0;
    ev_rel   = 1'b0;
    if (read_data) begin
      if (state_q == StPause) begin
        // Pause bytes are swallowed even if they look like control bytes
        skip_d = skip_q - 3'd1;
        if (skip_q == 3'd1) state_d = StIdle;
      end else if (is_ctrl) begin
        state_d = StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (rx_data == 8'hE0) state_d = StExt;
            else if (rx_data == 8'hF0) state_d = StBrk;
            else if (rx_data == 8'hE1) begin
              state_d = StPause;
              skip_d  = 3'd7;
            end else ev_valid = 1'b1;
          end
          StExt: begin
            if (rx_data == 8'hF0) state_d = StExtBrk;
            else begin
              state_d  = StIdle;
              ev_valid = (rx_data != 8'h12);  // E0 12 is a fake shift
              ev_ext   = 1'b1;
            end
          end
          StBrk: begin
            state_d  = StIdle;
            ev_valid = 1'b1;
            ev_rel   = 1'b1;
          end
          StExtBrk: begin
            state_d  = StIdle;
            ev_valid = (rx_data != 8'h12);
            ev_ext   = 1'b1;
            ev_rel   = 1'b1;
          end
          default: state_d = StIdle;
        endcase
      end
    end else if (state_q != StIdle) begin
      if (tmo_q == TmoLast) state_d = StIdle;
      else tmo_d = tmo_q + TW'(1);
    end
  end

  // Held-key bitmap next state; tracks every decoded event, queued or not
  always_comb begin
    held_d = held_q;
    if (ev_valid) held_d[{ev_ext, ev_code}] = ~ev_rel;
  end

`ifdef REPEAT_FILTER_EN
  assign ev_keep = ev_rel ? held_q[{ev_ext, ev_code}] : ~held_q[{ev_ext, ev_code}];
`else
  assign ev_keep = 1'b1;
`endif

  assign pop  = (count_q != '0) && evt_ready;
  assign full = (count_q == (AW + 1)'(FIFO_DEPTH));
  // A pop in the same cycle frees a slot, so a full FIFO still accepts
  assign push = ev_valid && ev_keep && (!full || pop);
  assign drop = ev_valid && ev_keep && full && !pop;

  // FIFO occupancy next state
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state, pointers and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      skip_q  <= '0;
      tmo_q   <= '0;
      held_q  <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      tmo_q   <= tmo_d;
      held_q  <= held_d;
      count_q <= count_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      if (drop) ovf_q <= 1'b1;
      last_q  <= {evt_ext, evt_release, evt_code};
    end
  end

  // Event storage, packed as {ext, release, code}
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= {ev_ext, ev_rel, ev_code};
  end

  assign evt_valid  = (count_q != '0);
  // When empty, outputs keep showing the last head that was presented
  assign {evt_ext, evt_release, evt_code} = evt_valid ? mem[rptr_q] : last_q;
  assign fifo_level = count_q;
  assign overflow   = ovf_q;

endmodule
